// File: rtl/ucaspian_step_ctrl.sv
// -----------------------------------------------------------------------------
// ucaspian_step_ctrl
//
// Timestep sequencer for the uCaspian core.
// - RUN: issues one next_step pulse per timestep. After each pulse it waits
//   SETTLE_CYCLES cycles, then waits for every datapath unit to report
//   step_done. This repeats until the requested number of steps is done.
// - CLEAR_ACT / CLEAR_CONFIG: holds the matching clear level until every unit
//   reports clear_done.
// - run_done pulses once when a RUN or a clear completes.
//
// Optional feature: define UCASPIAN_STEP_TIMEOUT_EN to add a watchdog on the
// WAIT and CLEAR states. It sets the sticky timeout flag after TIMEOUT_CYCLES
// cycles. Without the macro, timeout is tied low and the FSM waits
// indefinitely.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_op[1:0]         0=NOP 1=RUN 2=CLEAR_ACT 3=CLEAR_CONFIG
//   cmd_steps[15:0]     timesteps to run for RUN
//   cmd_vld / cmd_rdy   command handshake; cmd_rdy is high only in IDLE
//   done_step[N-1:0]    per-unit step_done
//   done_clear[N-1:0]   per-unit clear_done
//   next_step           one-cycle timestep advance pulse
//   clear_act           level, held until the activity clear completes
//   clear_config        level, held until the config clear completes
//   step_count[15:0]    steps completed in the current/last RUN
//   busy                registered "FSM not IDLE"
//   run_done            one-cycle completion pulse
//   timeout             sticky watchdog flag
// -----------------------------------------------------------------------------
module ucaspian_step_ctrl #(
   parameter int NUM_UNITS      = 3,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           cmd_op,
   input  logic [15:0]          cmd_steps,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   input  logic [NUM_UNITS-1:0] done_step,
   input  logic [NUM_UNITS-1:0] done_clear,
   output logic                 next_step,
   output logic                 clear_act,
   output logic                 clear_config,
   output logic [15:0]          step_count,
   output logic                 busy,
   output logic                 run_done,
   output logic                 timeout
);

   typedef enum logic [2:0] {S_IDLE, S_STEP, S_SETTLE, S_WAIT, S_CLEAR} state_t;

   localparam logic [1:0] OP_NOP     = 2'd0;
   localparam logic [1:0] OP_RUN     = 2'd1;
   localparam logic [1:0] OP_CLR_ACT = 2'd2;
   localparam logic [1:0] OP_CLR_CFG = 2'd3;

   // The settle counter must be able to hold SETTLE_CYCLES itself, even when
   // SETTLE_CYCLES is 0.
   localparam int             SW         = $clog2(SETTLE_CYCLES + 2);
   localparam logic [SW-1:0]  SETTLE_MAX = SW'(SETTLE_CYCLES);

   // Reject nonsensical parameter values at elaboration time.
   if (NUM_UNITS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("ucaspian_step_ctrl: NUM_UNITS and TIMEOUT_CYCLES must be >= 1");
   end

   state_t          state_q, state_d;
   logic [15:0]     target_q, target_d;
   logic [15:0]     step_count_q, step_count_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            next_step_q, next_step_d;
   logic            clear_act_q, clear_act_d;
   logic            clear_config_q, clear_config_d;
   logic            busy_q, busy_d;
   logic            run_done_q, run_done_d;
   logic            clear_ok;

`ifdef UCASPIAN_STEP_TIMEOUT_EN
   localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]   wd_q, wd_d;
   logic            timeout_q, timeout_d;
`endif

   // NOTE: every variable gets its default before the case statement. Any
   // path that left one unassigned would infer a latch.
   always_comb begin
      state_d        = state_q;
      target_d       = target_q;
      step_count_d   = step_count_q;
      settle_d       = settle_q;
      clear_act_d    = clear_act_q;
      clear_config_d = clear_config_q;
      run_done_d     = 1'b0;
      clear_ok       = 1'b0;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
      wd_d           = wd_q;
      timeout_d      = timeout_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_vld) begin
`ifdef UCASPIAN_STEP_TIMEOUT_EN
               if (cmd_op != OP_NOP) timeout_d = 1'b0;
`endif
               settle_d = '0;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
               wd_d     = '0;
`endif
               case (cmd_op)
                  OP_RUN: begin
                     target_d     = cmd_steps;
                     step_count_d = 16'd0;
                     // A zero-step RUN completes immediately without stepping.
                     if (cmd_steps == 16'd0) run_done_d = 1'b1;
                     else                    state_d    = S_STEP;
                  end
                  OP_CLR_ACT: begin
                     state_d     = S_CLEAR;
                     clear_act_d = 1'b1;
                  end
                  OP_CLR_CFG: begin
                     state_d        = S_CLEAR;
                     clear_config_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         S_STEP: begin
            settle_d = '0;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
            wd_d     = '0;
`endif
            state_d  = (SETTLE_CYCLES == 0) ? S_WAIT : S_SETTLE;
         end

         // Units register their done outputs, so for the first few cycles
         // after a step those outputs still reflect the previous step.
         S_SETTLE: begin
            settle_d = settle_q + 1'b1;
            if (settle_d == SETTLE_MAX) state_d = S_WAIT;
         end

         S_WAIT: begin
            if (&done_step) begin
               // target <= 65535 and count < target here, so this cannot wrap.
               step_count_d = step_count_q + 16'd1;
               if (step_count_d == target_q) begin
                  state_d    = S_IDLE;
                  run_done_d = 1'b1;
               end else begin
                  state_d = S_STEP;
               end
            end
`ifdef UCASPIAN_STEP_TIMEOUT_EN
            else if (wd_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end

         S_CLEAR: begin
            if (settle_q != SETTLE_MAX) settle_d = settle_q + 1'b1;
            clear_ok = (settle_q == SETTLE_MAX) && (&done_clear);
            if (clear_ok) begin
               clear_act_d    = 1'b0;
               clear_config_d = 1'b0;
               run_done_d     = 1'b1;
               state_d        = S_IDLE;
            end
`ifdef UCASPIAN_STEP_TIMEOUT_EN
            else if (wd_q == TO_LAST) begin
               clear_act_d    = 1'b0;
               clear_config_d = 1'b0;
               timeout_d      = 1'b1;
               state_d        = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end

         default: state_d = S_IDLE;
      endcase

      // next_step and busy are registered copies of the next-state decode.
      // Both therefore line up exactly with state_q.
      next_step_d = (state_d == S_STEP);
      busy_d      = (state_d != S_IDLE);
   end

   // NOTE: state updates use non-blocking assignments, so every flop samples
   // values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         target_q       <= 16'd0;
         step_count_q   <= 16'd0;
         settle_q       <= '0;
         next_step_q    <= 1'b0;
         clear_act_q    <= 1'b0;
         clear_config_q <= 1'b0;
         busy_q         <= 1'b0;
         run_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         step_count_q   <= step_count_d;
         settle_q       <= settle_d;
         next_step_q    <= next_step_d;
         clear_act_q    <= clear_act_d;
         clear_config_q <= clear_config_d;
         busy_q         <= busy_d;
         run_done_q     <= run_done_d;
      end
   end

`ifdef UCASPIAN_STEP_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign cmd_rdy      = (state_q == S_IDLE);
   assign next_step    = next_step_q;
   assign clear_act    = clear_act_q;
   assign clear_config = clear_config_q;
   assign step_count   = step_count_q;
   assign busy         = busy_q;
   assign run_done     = run_done_q;

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ucaspian_step_ctrl
//
// Scoreboard bench for ucaspian_step_ctrl. Each stimulus step pushes the
// next_step and run_done pulses it should produce into a queue. Each queue
// entry holds the expected cycle and the step_count value at that pulse. A
// monitor pops and compares on every pulse the DUT presents. Level outputs
// are checked directly with check().
// Cycle numbering: cyc increments at every rising edge. A command accepted at
// an edge gets acc = cyc after that edge, so the cycle right after acceptance
// is cycle acc.
// -----------------------------------------------------------------------------
module tb_ucaspian_step_ctrl;

   localparam int NU = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    cmd_op = 2'd0;
   logic [15:0]   cmd_steps = 16'd0;
   logic          cmd_vld = 1'b0;
   logic          cmd_rdy;
   logic [NU-1:0] done_step = '0;
   logic [NU-1:0] done_clear = '0;
   logic          next_step, clear_act, clear_config, busy, run_done, timeout;
   logic [15:0]   step_count;

   always #5 clk = ~clk;

   ucaspian_step_ctrl #(
      .NUM_UNITS(NU), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
      .done_step(done_step), .done_clear(done_clear),
      .next_step(next_step), .clear_act(clear_act), .clear_config(clear_config),
      .step_count(step_count), .busy(busy), .run_done(run_done), .timeout(timeout)
   );

   // kind: 0 = next_step pulse, 1 = run_done pulse, 2 = both at once
   typedef struct {
      int kind;
      int cyc;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input int cnt);
      ev_t e;
      e.kind = kind; e.cyc = c; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int  m_kind;
   ev_t m_e;
   always @(negedge clk) begin
      if (!reset && (next_step || run_done)) begin
         m_kind = next_step ? (run_done ? 2 : 0) : 1;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got kind=%0d at cycle %0d, want none", m_kind, cyc);
         end else begin
            m_e = exp_q.pop_front();
            check("pulse_kind", m_kind, m_e.kind);
            check("pulse_cycle", cyc, m_e.cyc);
            check("pulse_step_count", int'(step_count), m_e.cnt);
            if (m_kind == 0) check("step_during_clear", int'(clear_act | clear_config), 0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic at_cycle(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] steps, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      cmd_op = op; cmd_steps = steps; cmd_vld = 1'b1;
      while (!cmd_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_rdy) check("cmd_accept", int'(cmd_rdy), 1);
      acc = cyc + 1;
      @(posedge clk);
      #1 cmd_vld = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_rdy && n < budget);
      check("reached_idle", int'(cmd_rdy), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_next_step"},    int'(next_step), 0);
      check({tag, "_clear_act"},    int'(clear_act), 0);
      check({tag, "_clear_config"}, int'(clear_config), 0);
      check({tag, "_run_done"},     int'(run_done), 0);
      check({tag, "_busy"},         int'(busy), 0);
      check({tag, "_step_count"},   int'(step_count), 0);
      check({tag, "_timeout"},      int'(timeout), 0);
      check({tag, "_cmd_rdy"},      int'(cmd_rdy), 1);
   endtask

   // ---------------- directed sequence ----------------
   int a, b;
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;

      // NOP leaves everything alone
      issue(2'd0, 16'd5, a);
      at_cycle(a + 1);
      check("nop_busy", int'(busy), 0);
      check("nop_cmd_rdy", int'(cmd_rdy), 1);
      check("nop_step_count", int'(step_count), 0);

      // RUN 3 with all units always done: pulses 4 cycles apart
      done_step = 3'b111;
      issue(2'd1, 16'd3, a);
      expect_ev(0, a, 0); expect_ev(0, a + 4, 1); expect_ev(0, a + 8, 2);
      expect_ev(1, a + 12, 3);
      at_cycle(a + 1);
      check("run3_cmd_rdy", int'(cmd_rdy), 0);
      check("run3_busy", int'(busy), 1);
      wait_idle(50);
      check("run3_final_count", int'(step_count), 3);

      // RUN 2 with unit 1 stalled: second pulse waits for it
      done_step = 3'b101;
      issue(2'd1, 16'd2, a);
      expect_ev(0, a, 0); expect_ev(0, a + 21, 1); expect_ev(1, a + 25, 2);
      at_cycle(a + 10);
      check("stall_count", int'(step_count), 0);
      check("stall_busy", int'(busy), 1);
      at_cycle(a + 20);
      done_step = 3'b111;
      wait_idle(50);
      check("stall_final_count", int'(step_count), 2);

      // RUN 0: immediate run_done, no step
      issue(2'd1, 16'd0, a);
      expect_ev(1, a, 0);
      at_cycle(a);
      check("run0_cmd_rdy", int'(cmd_rdy), 1);
      check("run0_count", int'(step_count), 0);

      // CLEAR_ACT with done_clear already high: ignored for 2 settle cycles
      done_clear = 3'b111;
      issue(2'd2, 16'd0, a);
      expect_ev(1, a + 3, 0);
      at_cycle(a);
      check("clra_level_first", int'(clear_act), 1);
      check("clra_cfg_low", int'(clear_config), 0);
      at_cycle(a + 2);
      check("clra_level_last", int'(clear_act), 1);
      at_cycle(a + 3);
      check("clra_dropped", int'(clear_act), 0);
      check("clra_cmd_rdy", int'(cmd_rdy), 1);
      done_clear = '0;

      // CLEAR_CONFIG with a RUN held off behind it
      issue(2'd3, 16'd0, a);
      cmd_op = 2'd1; cmd_steps = 16'd0; cmd_vld = 1'b1;
      expect_ev(1, a + 5, 0);   // clear completes
      expect_ev(1, a + 6, 0);   // held-off zero-step RUN then completes
      for (int k = 0; k < 5; k++) begin
         at_cycle(a + k);
         check("clrc_cmd_rdy", int'(cmd_rdy), 0);
         check("clrc_level", int'(clear_config), 1);
         check("clrc_act_low", int'(clear_act), 0);
         if (k == 4) done_clear = 3'b111;
      end
      at_cycle(a + 5);
      check("clrc_dropped", int'(clear_config), 0);
      check("clrc_cmd_rdy_back", int'(cmd_rdy), 1);
      @(posedge clk);
      #1 cmd_vld = 1'b0;
      done_clear = '0;

      // RUN 100, reset during step 5 WAIT
      done_step = 3'b111;
      issue(2'd1, 16'd100, a);
      for (int k = 0; k < 5; k++) expect_ev(0, a + 4 * k, k);
      at_cycle(a + 19);
      check("midrun_busy", int'(busy), 1);
      check("midrun_count", int'(step_count), 4);
      reset = 1'b1;
      at_cycle(a + 20);
      check_reset_vals("abort");
      reset = 1'b0;
      repeat (8) @(negedge clk);

`ifdef UCASPIAN_STEP_TIMEOUT_EN
      // Watchdog: WAIT never satisfied
      done_step = '0;
      issue(2'd1, 16'd1, a);
      expect_ev(0, a, 0);
      at_cycle(a + 18);
      check("wd_not_yet", int'(timeout), 0);
      check("wd_busy", int'(busy), 1);
      at_cycle(a + 19);
      check("wd_timeout", int'(timeout), 1);
      check("wd_idle", int'(cmd_rdy), 1);
      check("wd_busy_low", int'(busy), 0);
      issue(2'd1, 16'd0, b);
      expect_ev(1, b, 0);
      at_cycle(b);
      check("wd_cleared", int'(timeout), 0);
`else
      check("timeout_tied_low", int'(timeout), 0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got still running, want finished");
      $fatal(1, "time limit");
   end

endmodule
